xseq_synth: RTL

//  Memory-mapped NCH-channel square-wave step sequencer on the controller data bus.

---
 rtl/xseq_synth_if.sv | 19 +
 rtl/xseq_synth.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/xseq_synth_if.sv
// xseq_synth_if: controller data-bus bundle for the step sequencer.
//   sel      block select from the address decoder
//   we       write enable, qualified by sel
//   addr     word address within the block
//   data_in  write data
//   data_out read data (0 when sel=0)
// master drives the request side; slave (the sequencer) returns read data.
interface xseq_synth_if #(
  parameter int DATA_W = 32
);
  logic              sel;
  logic              we;
  logic [4:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, we, addr, data_in, input data_out);
  modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/xseq_synth.sv
// xseq_synth: memory-mapped NCH-channel square-wave step sequencer.
//   clk      system clock
//   rst      synchronous reset, active-high; clears every register incl. pattern memory
//   bus      register bus (slave side): CTRL 0x00, TEMPO 0x01, STATUS 0x02 (RO),
//            PERIOD[i] 0x04+i, PATTERN[s] 0x10+s; reads combinational, 0 when sel=0
//   kbd_in   keyboard inputs, bit i gates channel i when kbd_mode=1
//   snd_out  registered OR of gated channel square waves
//   led_out  registered one-hot step indicator (0 while stopped)
module xseq_synth #(
  parameter int DATA_W  = 32,
  parameter int NCH     = 4,
  parameter int STEPS   = 16,
  parameter int DIV_W   = 20,
  parameter int TEMPO_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  xseq_synth_if.slave  bus,
  input  logic [7:0]   kbd_in,
  output logic         snd_out,
  output logic [7:0]   led_out
);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  logic               run_q, loop_q, kbd_q, done_q;
  logic [TEMPO_W-1:0] tempo_q, tick_q;
  logic [3:0]         step_q;
  logic [7:0]         wrap_q;
  logic [DIV_W-1:0]   period_q [NCH];
  logic [DIV_W-1:0]   cnt_q    [NCH];
  logic [NCH-1:0]     sq_q;
  logic [NCH-1:0]     pattern_q [STEPS];
  logic               snd_q;
  logic [7:0]         led_q;

  logic               wr, ctrl_wr, tempo_wr, per_wr, pat_wr;
  logic               adv, at_end;
  logic [NCH-1:0]     gate;
  logic [DATA_W-1:0]  rd;

  always_comb begin
    wr       = bus.sel & bus.we;
    ctrl_wr  = wr && (bus.addr == 5'h00);
    tempo_wr = wr && (bus.addr == 5'h01);
    per_wr   = wr && (bus.addr[4:2] == 3'b001) && (32'(bus.addr[1:0]) < NCH);
    pat_wr   = wr && bus.addr[4] && (32'(bus.addr[3:0]) < STEPS);
    // >= rather than == so a TEMPO shrunk below the current tick advances at once
    adv      = run_q && (tempo_q != '0) && (tick_q >= tempo_q - TEMPO_W'(1));
    at_end   = (step_q == LAST_STEP);
    for (int unsigned i = 0; i < NCH; i++) begin
      gate[i] = (run_q & pattern_q[step_q[SW-1:0]][i]) | (kbd_q & kbd_in[i]);
    end
  end

  always_comb begin
    rd = '0;
    if (bus.sel) begin
      if (bus.addr == 5'h00) begin
        rd[2:0] = {kbd_q, loop_q, run_q};
      end else if (bus.addr == 5'h01) begin
        rd[TEMPO_W-1:0] = tempo_q;
      end else if (bus.addr == 5'h02) begin
        rd[3:0]   = step_q;
        rd[8]     = run_q;
        rd[9]     = done_q;
        rd[23:16] = wrap_q;
      end else if ((bus.addr[4:2] == 3'b001) && (32'(bus.addr[1:0]) < NCH)) begin
        rd[DIV_W-1:0] = period_q[bus.addr[1:0]];
      end else if (bus.addr[4] && (32'(bus.addr[3:0]) < STEPS)) begin
        rd[NCH-1:0] = pattern_q[bus.addr[SW-1:0]];
      end
    end
  end
  assign bus.data_out = rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      loop_q  <= 1'b0;
      kbd_q   <= 1'b0;
      done_q  <= 1'b0;
      tempo_q <= '0;
      tick_q  <= '0;
      step_q  <= '0;
      wrap_q  <= '0;
      sq_q    <= '0;
      snd_q   <= 1'b0;
      led_q   <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      for (int unsigned s = 0; s < STEPS; s++) begin
        pattern_q[s] <= '0;
      end
    end else begin
      // Sequencer timing; a same-cycle CTRL write below overrides these.
      if (run_q && (tempo_q != '0)) begin
        tick_q <= adv ? '0 : tick_q + TEMPO_W'(1);
      end
      if (adv) begin
        if (!at_end) begin
          step_q <= step_q + 4'd1;
        end else if (!ctrl_wr) begin
          if (loop_q) begin
            step_q <= '0;
            wrap_q <= wrap_q + 8'd1;
          end else begin
            run_q  <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end
      if (ctrl_wr) begin
        loop_q <= bus.data_in[1];
        kbd_q  <= bus.data_in[2];
        if (bus.data_in[0] && !run_q) begin
          run_q  <= 1'b1;
          tick_q <= '0;
          step_q <= '0;
          done_q <= 1'b0;
          wrap_q <= '0;
        end else if (!bus.data_in[0]) begin
          run_q <= 1'b0;
        end
      end
      if (tempo_wr) begin
        tempo_q <= bus.data_in[TEMPO_W-1:0];
      end
      if (pat_wr) begin
        pattern_q[bus.addr[SW-1:0]] <= bus.data_in[NCH-1:0];
      end

      for (int unsigned i = 0; i < NCH; i++) begin
        if (per_wr && (32'(bus.addr[1:0]) == i)) begin
          period_q[i] <= bus.data_in[DIV_W-1:0];
          cnt_q[i]    <= '0;
          sq_q[i]     <= 1'b0;
        end else if (period_q[i] == '0) begin
          cnt_q[i] <= '0;
          sq_q[i]  <= 1'b0;
        end else if (cnt_q[i] >= period_q[i] - DIV_W'(1)) begin
          cnt_q[i] <= '0;
          sq_q[i]  <= ~sq_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + DIV_W'(1);
        end
      end

      snd_q <= |(sq_q & gate);
      led_q <= run_q ? 8'(8'b1 << step_q[2:0]) : 8'h00;
    end
  end

  assign snd_out = snd_q;
  assign led_out = led_q;
endmodule
